bitrev_pipe: RTL and testbench

BITREV_PIPE -- requirements
Module: bitrev_pipe

---
 rtl/bitrev_pipe_pkg.sv | 20 ++
 rtl/bitperm_comb.sv | 45 ++++
 rtl/bitrev_pipe.sv | 116 +++++++++++
 tb/tb_bitrev_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitrev_pipe_pkg.sv
// Shared definitions for the bit/byte permutation pipeline: mode encodings
// and the legal-width rule, imported by the datapath and by the bench.
package bitrev_pipe_pkg;

    // Operation select carried on in_mode
    typedef enum logic [1:0] {
        MODE_BITREV  = 2'b00,
        MODE_BYTEREV = 2'b01,
        MODE_PASS    = 2'b10,
        MODE_FIELD   = 2'b11
    } mode_e;

    localparam int unsigned ModeW = 2;

    // Data width must be a whole number of bytes, at least one byte
    function automatic bit width_ok(int unsigned w);
        return (w >= 8) && ((w % 8) == 0);
    endfunction

endpackage

// File: rtl/bitperm_comb.sv
// Purely combinational permutation network: bit reverse, byte reverse,
// pass-through, or reversal of the low L bits with the upper bits kept.
// The length input is expected to be already clamped to WIDTH.
module bitperm_comb
    import bitrev_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  mode_e            mode,
    input  logic [LW-1:0]    len,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] bit_rev;
    logic [WIDTH-1:0] byte_rev;
    logic [WIDTH-1:0] field_low;
    logic [WIDTH-1:0] field_mask;
    logic [WIDTH-1:0] field_rev;

    // Full reversals; the field result reuses the full bit reversal, shifted
    // down so that bit L-1 of A lands at bit 0.  A shift by WIDTH (len = 0)
    // yields all zeros, and the mask then selects A unchanged.
    always_comb begin
        bit_rev    = {<<{a}};
        byte_rev   = {<<8{a}};
        field_low  = bit_rev >> (LW'(WIDTH) - len);
        field_mask = ~({WIDTH{1'b1}} << len);
        field_rev  = (field_low & field_mask) | (a & ~field_mask);
    end

    // Select the requested permutation
    always_comb begin
        result = a;
        unique case (mode)
            MODE_BITREV:  result = bit_rev;
            MODE_BYTEREV: result = byte_rev;
            MODE_PASS:    result = a;
            MODE_FIELD:   result = field_rev;
            default:      result = a;
        endcase
    end

endmodule

// File: rtl/bitrev_pipe.sv
// Two-stage valid/ready pipeline around bitperm_comb.  Stage 1 captures the
// operand, mode and clamped field length; stage 2 captures the permuted
// result.  The only combinational input-to-output path is out_ready to
// in_ready.
module bitrev_pipe
    import bitrev_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [LW-1:0]    in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (!width_ok(WIDTH)) begin : gen_bad_width
        $error("bitrev_pipe: WIDTH=%0d must be a multiple of 8 and >= 8", WIDTH);
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    mode_e            s1_mode_q, s1_mode_d;
    logic [LW-1:0]    s1_len_q, s1_len_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [LW-1:0]    len_clamped;
    logic [WIDTH-1:0] perm_result;

    // Handshake: stage 2 moves when empty or drained; stage 1 follows it
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_adv;
        in_ready = !s1_valid_q || s1_adv;
        accept   = in_valid && in_ready;
    end

    // Clamp the field length so the permutation only ever sees 0..WIDTH
    always_comb begin
        len_clamped = (in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
    end

    // Stage 1 next state: load on accept, otherwise empty out when it moves on
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_len_d   = s1_len_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_mode_d  = mode_e'(in_mode);
            s1_len_d   = len_clamped;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    bitperm_comb #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_perm (
        .a      (s1_data_q),
        .mode   (s1_mode_q),
        .len    (s1_len_q),
        .result (perm_result)
    );

    // Stage 2 next state: a stage-1 bubble clears s2_valid when stage 2 moves
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = perm_result;
            end
        end
    end

    // Pipeline registers; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= MODE_BITREV;
            s1_len_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_len_q   <= s1_len_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // Outputs come straight from stage-2 flops
    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
    end

endmodule

// File: tb/tb_bitrev_pipe.sv
// Self-checking bench for bitrev_pipe at WIDTH=16: directed cases, back-
// pressure, streaming, random valid/ready and mid-operation reset, with a
// scoreboard fed by a per-bit reference model.
module tb_bitrev_pipe;
    import bitrev_pipe_pkg::*;

    localparam int W  = 16;
    localparam int LW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_mode;
    logic [LW-1:0] in_len;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    logic [W-1:0] sb[$];

    bitrev_pipe #(
        .WIDTH (W),
        .LW    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    // Reference: each output bit computed from the mode's index rule
    function automatic logic [W-1:0] ref_perm(input logic [W-1:0] a, input logic [1:0] m,
                                              input int len);
        logic [W-1:0] r;
        int l;
        r = '0;
        l = (len > W) ? W : len;
        case (m)
            MODE_BITREV: begin
                for (int i = 0; i < W; i++)
                    if ((a & (16'd1 << i)) != 0) r = r | (16'h8000 >> i);
            end
            MODE_BYTEREV: r = {a[7:0], a[15:8]};
            MODE_PASS:    r = a;
            default: begin
                for (int i = 0; i < W; i++) begin
                    if (i < l) begin
                        if ((a & (16'd1 << (l - 1 - i))) != 0) r = r | (16'd1 << i);
                    end else if ((a & (16'd1 << i)) != 0) begin
                        r = r | (16'd1 << i);
                    end
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: handshakes decided mid-cycle, ahead of the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
                else check("sb_data", {16'd0, out_data}, {16'd0, sb.pop_front()});
            end
            if (in_valid && in_ready)
                sb.push_back(ref_perm(in_data, in_mode, int'(in_len)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated word: check the 2-edge latency and the expected result
    task automatic send_one(input logic [W-1:0] a, input logic [1:0] m, input int len,
                            input logic [W-1:0] exp);
        in_valid = 1'b1;
        in_data  = a;
        in_mode  = m;
        in_len   = LW'(len);
        step();
        in_valid = 1'b0;
        check("lat_early", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_data", {16'd0, out_data}, {16'd0, exp});
    endtask

    logic [W-1:0] w[3];
    logic [1:0]   wm[3];
    int           wl[3];
    logic         prev_stall;
    logic [W-1:0] prev_data;
    int           n_before;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_data", {16'd0, out_data}, 32'd0);

        // Directed mode cases
        send_one(16'h0001, MODE_BITREV, 0, 16'h8000);
        send_one(16'h1234, MODE_BYTEREV, 0, 16'h3412);
        send_one(16'h1234, MODE_PASS, 0, 16'h1234);
        send_one(16'hABC1, MODE_FIELD, 4, 16'hABC8);
        send_one(16'hABC1, MODE_FIELD, 0, 16'hABC1);
        send_one(16'hABC1, MODE_FIELD, 20, 16'h83D5);
        send_one(16'hABC1, MODE_FIELD, 16, 16'h83D5);
        send_one(16'hABC1, MODE_BITREV, 0, 16'h83D5);
        step();

        // Back-pressure: two words fill the pipe, third waits
        for (int i = 0; i < 3; i++) begin
            w[i]  = W'($urandom);
            wm[i] = 2'($urandom_range(0, 3));
            wl[i] = $urandom_range(0, 31);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = w[0];
        in_mode   = wm[0];
        in_len    = LW'(wl[0]);
        step();
        check("bp_rdy_one", {31'd0, in_ready}, 32'd1);
        in_data = w[1];
        in_mode = wm[1];
        in_len  = LW'(wl[1]);
        step();
        in_data = w[2];
        in_mode = wm[2];
        in_len  = LW'(wl[2]);
        for (int k = 0; k < 3; k++) begin
            check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_r0", {16'd0, out_data}, {16'd0, ref_perm(w[0], wm[0], wl[0])});
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_comb_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_r1", {16'd0, out_data}, {16'd0, ref_perm(w[1], wm[1], wl[1])});
        check("bp_r1_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_r2", {16'd0, out_data}, {16'd0, ref_perm(w[2], wm[2], wl[2])});
        check("bp_r2_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate
        n_before = n_out;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_mode  = 2'($urandom_range(0, 3));
            in_len   = LW'($urandom_range(0, 31));
            step();
            if (i > 0) check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_last", {31'd0, out_valid}, 32'd1);
        step();
        check("stream_done", {31'd0, out_valid}, 32'd0);
        check("stream_count", n_out - n_before, 32'd64);

        // Random valid/ready with hold-while-stalled checks
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            in_len    = LW'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk);
            #1;
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {16'd0, out_data}, {16'd0, prev_data});
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        check("drain_empty", sb.size(), 32'd0);

        // Mid-operation reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hF00D;
        in_mode   = MODE_PASS;
        step();
        in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_rdy", {31'd0, in_ready}, 32'd1);
        check("arst_data", {16'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        step();
        check("no_stale", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00F1;
        in_mode   = MODE_FIELD;
        in_len    = LW'(8);
        step();
        in_valid = 1'b0;
        step();
        check("first_post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("first_post_rst_data", {16'd0, out_data}, 32'h0000_008F);
        step();
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
